// File: rtl/wave_ctrl.sv
// rtl/wave_ctrl.sv - run-control sequencer and phase accumulator for the waveform ROM
// Define WAVE_CTRL_SWEEP_EN to compile in the linear frequency sweep applied at each wrap.
module wave_ctrl #(
  parameter int ACC_W = 24,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [ACC_W-1:0] ftw,
  input  logic [1:0]       wave_sel,
`ifdef WAVE_CTRL_SWEEP_EN
  input  logic [ACC_W-1:0] ftw_step,
  input  logic [ACC_W-1:0] ftw_limit,
`endif
  output logic             rom_en,
  output logic [1:0]       rom_select,
  output logic [7:0]       rom_phase,
  output logic             sample_valid,
  output logic             wrap,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int               CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] prime_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw_act;
  logic [1:0]       sel_act;
  logic [LAT-1:0]   valid_sr;
  logic [ACC_W:0]   acc_sum;
  logic             carry;
  logic [ACC_W-1:0] ftw_reload;

  assign acc_sum = {1'b0, acc} + {1'b0, ftw_act};
  assign carry   = acc_sum[ACC_W];

`ifdef WAVE_CTRL_SWEEP_EN
  // Extra sum bit keeps the clamp correct when ftw_act + ftw_step overflows ACC_W.
  logic [ACC_W:0] sweep_sum;
  assign sweep_sum  = {1'b0, ftw_act} + {1'b0, ftw_step};
  assign ftw_reload = (sweep_sum > {1'b0, ftw_limit}) ? ftw_limit : sweep_sum[ACC_W-1:0];
`else
  assign ftw_reload = ftw;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_PRIME;
      S_PRIME: begin
        if (stop)                       state_nxt = S_IDLE;
        else if (prime_cnt == CNT_LAST) state_nxt = S_RUN;
      end
      S_RUN:   if (stop) state_nxt = S_DRAIN;
      S_DRAIN: if (carry || (ftw_act == '0)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      prime_cnt <= '0;
      acc       <= '0;
      ftw_act   <= '0;
      sel_act   <= 2'b00;
      wrap      <= 1'b0;
      rom_en    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state  <= state_nxt;
      rom_en <= (state_nxt != S_IDLE);
      busy   <= (state_nxt != S_IDLE);
      wrap   <= 1'b0;
      case (state)
        S_IDLE: begin
          acc       <= '0;
          prime_cnt <= '0;
          if (start) begin
            ftw_act <= ftw;
            sel_act <= wave_sel;
          end
        end
        S_PRIME: begin
          acc       <= '0;
          prime_cnt <= prime_cnt + CNT_W'(1);
        end
        S_RUN: begin
          acc  <= acc_sum[ACC_W-1:0];
          wrap <= carry;
          // Reload on the carry edge so the new waveform starts exactly at phase wrap.
          if (carry) begin
            ftw_act <= ftw_reload;
            sel_act <= wave_sel;
          end
        end
        S_DRAIN: begin
          wrap <= carry;
          acc  <= (state_nxt == S_IDLE) ? '0 : acc_sum[ACC_W-1:0];
        end
        default: acc <= '0;
      endcase
    end
  end

  // Shift register tracks ROM pipeline latency; cleared together with rom_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_sr <= '0;
    end else if (state_nxt == S_IDLE) begin
      valid_sr <= '0;
    end else begin
      valid_sr[0] <= rom_en;
      for (int i = 1; i < LAT; i++) begin
        valid_sr[i] <= valid_sr[i-1];
      end
    end
  end

  assign sample_valid = valid_sr[LAT-1];
  assign rom_select   = sel_act;
  assign rom_phase    = acc[ACC_W-1 -: 8];

endmodule
